adc_dsp_reg_responder: RTL and testbench

// Bus responder for the ADC DSP control registers: RESET (0x0000), ERROR (0x0004), CHANNEL (0x0008).

---
 rtl/adc_dsp_reg_responder.sv | 135 +++++++++++++
 tb/tb_adc_dsp_reg_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dsp_reg_responder.sv
// Register-bus responder for the ADC DSP block: soft-reset pulse, sticky error flags and channel select.
// One command in flight at a time; the response is registered and held until the initiator takes it.
module adc_dsp_reg_responder #(
  parameter int                    ADDR_BITS     = 26,
  parameter int                    DATA_BITS     = 32,
  parameter logic [ADDR_BITS-17:0] CHIP_PREFIX   = 10'h223,
  parameter logic [3:0]            MOD_PREFIX    = 4'h0,
  parameter int                    ERR_BITS      = 8,
  parameter int                    RST_PULSE_CYC = 16
) (
  input  logic                 i_sysclk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [ADDR_BITS-1:0] i_cmd_addr,
  input  logic                 i_cmd_wr,
  input  logic [DATA_BITS-1:0] i_cmd_wdata,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_BITS-1:0] o_rsp_rdata,
  output logic                 o_rsp_err,
  input  logic [ERR_BITS-1:0]  i_err_set,
  output logic                 o_dsp_reset,
  output logic [7:0]           o_dsp_channel,
  output logic                 o_err_any
);

  localparam int CNT_W = $clog2(RST_PULSE_CYC + 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     pulseCnt_q, pulseCnt_d;
  logic                 dspReset_q, dspReset_d;
  logic [ERR_BITS-1:0]  errFlags_q, errFlags_d;
  logic [7:0]           channel_q, channel_d;
  logic [DATA_BITS-1:0] rspData_q, rspData_d;
  logic                 rspErr_q, rspErr_d;

  logic                 accept;
  logic                 addrMatch, selReset, selError, selChannel, hit;
  logic                 wrReset, wrChannel;
  logic [ERR_BITS-1:0]  errClr;
  logic [DATA_BITS-1:0] readData;
  logic                 unusedWdata;

  assign accept     = i_cmd_valid && o_cmd_ready;
  assign addrMatch  = (i_cmd_addr[ADDR_BITS-1:16] == CHIP_PREFIX) && (i_cmd_addr[15:12] == MOD_PREFIX);
  assign selReset   = addrMatch && (i_cmd_addr[11:0] == 12'h000);
  assign selError   = addrMatch && (i_cmd_addr[11:0] == 12'h004);
  assign selChannel = addrMatch && (i_cmd_addr[11:0] == 12'h008);
  assign hit        = selReset || selError || selChannel;

  assign wrReset    = accept && i_cmd_wr && selReset && i_cmd_wdata[0];
  assign wrChannel  = accept && i_cmd_wr && selChannel;
  assign errClr     = (accept && i_cmd_wr && selError) ? i_cmd_wdata[ERR_BITS-1:0] : '0;
  assign unusedWdata = ^i_cmd_wdata;

  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_cmd_valid) state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (state_q == IDLE);
    o_rsp_valid = (state_q == RESP);
  end

  // Read data reflects register contents before this cycle's updates take effect.
  always_comb begin
    readData = '0;
    if (selReset)        readData[0]            = (pulseCnt_q != '0);
    else if (selError)   readData[ERR_BITS-1:0] = errFlags_q;
    else if (selChannel) readData[7:0]          = channel_q;
  end

  always_comb begin
    rspData_d = rspData_q;
    rspErr_d  = rspErr_q;
    if (accept) begin
      rspErr_d  = !hit;
      rspData_d = i_cmd_wr ? '0 : readData;
    end
  end

  // A reset write while the pulse is running simply restarts the countdown.
  always_comb begin
    pulseCnt_d = pulseCnt_q;
    if (wrReset)                pulseCnt_d = CNT_W'(RST_PULSE_CYC);
    else if (pulseCnt_q != '0) pulseCnt_d = pulseCnt_q - CNT_W'(1);
    dspReset_d = (pulseCnt_d != '0);
  end

  always_comb begin
    errFlags_d = (errFlags_q & ~errClr) | i_err_set;
    channel_d  = wrChannel ? i_cmd_wdata[7:0] : channel_q;
  end

  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      pulseCnt_q <= '0;
      dspReset_q <= 1'b0;
      errFlags_q <= '0;
      channel_q  <= '0;
      rspData_q  <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      pulseCnt_q <= pulseCnt_d;
      dspReset_q <= dspReset_d;
      errFlags_q <= errFlags_d;
      channel_q  <= channel_d;
      rspData_q  <= rspData_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign o_rsp_rdata   = rspData_q;
  assign o_rsp_err     = rspErr_q;
  assign o_dsp_reset   = dspReset_q;
  assign o_dsp_channel = channel_q;
  assign o_err_any     = |errFlags_q;

endmodule

// File: tb/tb_adc_dsp_reg_responder.sv
// Scoreboard bench for adc_dsp_reg_responder: a cycle-level register model predicts every response,
// a monitor compares each presented response, plus directed pulse, error, miss, hold and abort cases.
module tb_adc_dsp_reg_responder;

  localparam logic [25:0] A_RESET = 26'h223_0000;
  localparam logic [25:0] A_ERR   = 26'h223_0004;
  localparam logic [25:0] A_CHAN  = 26'h223_0008;
  localparam int          PULSE   = 16;

  logic        i_sysclk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [25:0] i_cmd_addr = '0;
  logic        i_cmd_wr = 1'b0;
  logic [31:0] i_cmd_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [7:0]  i_err_set = '0;
  logic        o_dsp_reset;
  logic [7:0]  o_dsp_channel;
  logic        o_err_any;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   readyMode = 1;
  int   pulseCount = 0;

  logic       mBusy = 1'b0;
  logic [7:0] mErr = '0;
  logic [7:0] mChan = '0;
  int         mPulse = 0;

  adc_dsp_reg_responder dut (
    .i_sysclk      (i_sysclk),
    .i_rst         (i_rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wr      (i_cmd_wr),
    .i_cmd_wdata   (i_cmd_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .i_err_set     (i_err_set),
    .o_dsp_reset   (o_dsp_reset),
    .o_dsp_channel (o_dsp_channel),
    .o_err_any     (o_err_any)
  );

  always #5 i_sysclk = ~i_sysclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [25:0] addr, input logic [31:0] wdata,
                               input logic [7:0] errSet);
    int waited;
    waited = 0;
    @(posedge i_sysclk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_wr    = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wdata;
    i_err_set   = errSet;
    @(negedge i_sysclk);
    while (!o_cmd_ready && waited < 50) begin
      @(negedge i_sysclk);
      waited++;
    end
    checkOutput("cmd_accept", {31'b0, o_cmd_ready}, 32'd1);
    @(posedge i_sysclk); #1;
    i_cmd_valid = 1'b0;
    i_err_set   = '0;
  endtask

  // Response-ready driver: random back-pressure, always ready, or stalled.
  initial begin
    i_rsp_ready = 1'b1;
    forever begin
      @(posedge i_sysclk); #1;
      case (readyMode)
        0:       i_rsp_ready = ($urandom_range(0, 3) != 0);
        1:       i_rsp_ready = 1'b1;
        default: i_rsp_ready = 1'b0;
      endcase
    end
  end

  // Register model: checks the visible state, predicts the response of each accepted command,
  // then advances the registers by one cycle.
  always @(negedge i_sysclk) begin
    logic       accept;
    logic       reload;
    logic [7:0] clr;
    int         chip, modf, off;
    rsp_t       r;
    if (i_rst) begin
      mBusy  = 1'b0;
      mErr   = '0;
      mChan  = '0;
      mPulse = 0;
      expQ.delete();
    end else begin
      checkOutput("cmd_ready", {31'b0, o_cmd_ready}, {31'b0, !mBusy});
      checkOutput("rsp_valid", {31'b0, o_rsp_valid}, {31'b0, mBusy});
      checkOutput("dsp_reset", {31'b0, o_dsp_reset}, (mPulse > 0) ? 32'd1 : 32'd0);
      checkOutput("dsp_channel", {24'b0, o_dsp_channel}, {24'b0, mChan});
      checkOutput("err_any", {31'b0, o_err_any}, (mErr != 0) ? 32'd1 : 32'd0);
      accept = i_cmd_valid && !mBusy;
      reload = 1'b0;
      clr    = '0;
      if (mBusy && i_rsp_ready) mBusy = 1'b0;
      if (accept) begin
        chip    = int'(i_cmd_addr) / 65536;
        modf    = (int'(i_cmd_addr) / 4096) % 16;
        off     = int'(i_cmd_addr) % 4096;
        r.err   = !(chip == 'h223 && modf == 0 && (off == 0 || off == 4 || off == 8));
        r.rdata = 32'd0;
        if (!r.err && !i_cmd_wr) begin
          if (off == 0)      r.rdata = (mPulse > 0) ? 32'd1 : 32'd0;
          else if (off == 4) r.rdata = {24'b0, mErr};
          else               r.rdata = {24'b0, mChan};
        end
        expQ.push_back(r);
        mBusy = 1'b1;
        if (!r.err && i_cmd_wr) begin
          if (off == 0)      reload = i_cmd_wdata[0];
          else if (off == 4) clr = i_cmd_wdata[7:0];
          else               mChan = i_cmd_wdata[7:0];
        end
      end
      if (reload)          mPulse = PULSE;
      else if (mPulse > 0) mPulse = mPulse - 1;
      mErr = (mErr & ~clr) | i_err_set;
    end
  end

  // Monitor: compares every presented response cycle against the oldest prediction.
  always @(negedge i_sysclk) begin
    if (!i_rst && o_rsp_valid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h err %0d with nothing expected at %0t",
                 o_rsp_rdata, o_rsp_err, $time);
      end else begin
        checkOutput("rsp_rdata", o_rsp_rdata, expQ[0].rdata);
        checkOutput("rsp_err", {31'b0, o_rsp_err}, {31'b0, expQ[0].err});
        if (i_rsp_ready) void'(expQ.pop_front());
      end
    end
  end

  always @(negedge i_sysclk) begin
    if (o_dsp_reset) pulseCount++;
  end

  initial begin
    logic [25:0] addrPick[7];
    addrPick = '{A_RESET, A_ERR, A_CHAN, 26'h224_0008, 26'h223_1008, 26'h223_000C, 26'h000_0004};

    repeat (3) @(negedge i_sysclk);
    checkOutput("rst_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, o_rsp_err}, 32'd0);
    checkOutput("rst_dsp_reset", {31'b0, o_dsp_reset}, 32'd0);
    checkOutput("rst_dsp_channel", {24'b0, o_dsp_channel}, 32'd0);
    checkOutput("rst_err_any", {31'b0, o_err_any}, 32'd0);
    @(posedge i_sysclk); #1;
    i_rst = 1'b0;

    // Channel write/read and one-cycle response latency
    applyStimulus(1'b1, A_CHAN, 32'h0000_005A, 8'h00);
    checkOutput("rsp_latency", {31'b0, o_rsp_valid}, 32'd1);
    applyStimulus(1'b0, A_CHAN, 32'h0, 8'h00);
    repeat (2) @(negedge i_sysclk);
    checkOutput("chan_out", {24'b0, o_dsp_channel}, 32'h5A);

    // Single soft-reset pulse with a busy read in the middle
    repeat (2) @(posedge i_sysclk);
    pulseCount = 0;
    applyStimulus(1'b1, A_RESET, 32'h1, 8'h00);
    applyStimulus(1'b0, A_RESET, 32'h0, 8'h00);
    repeat (30) @(posedge i_sysclk);
    checkOutput("pulse_len_16", pulseCount, 32'd16);

    // Retrigger on pulse cycle 10 stretches the pulse to 26 cycles
    pulseCount = 0;
    applyStimulus(1'b1, A_RESET, 32'h1, 8'h00);
    repeat (8) @(posedge i_sysclk);
    applyStimulus(1'b1, A_RESET, 32'h1, 8'h00);
    repeat (40) @(posedge i_sysclk);
    checkOutput("pulse_len_26", pulseCount, 32'd26);
    applyStimulus(1'b1, A_RESET, 32'h2, 8'h00);
    repeat (3) @(negedge i_sysclk);
    checkOutput("pulse_bit0_only", {31'b0, o_dsp_reset}, 32'd0);

    // Sticky error, set-beats-clear, then clear
    @(posedge i_sysclk); #1;
    i_err_set = 8'h04;
    @(posedge i_sysclk); #1;
    i_err_set = 8'h00;
    applyStimulus(1'b0, A_ERR, 32'h0, 8'h00);
    @(negedge i_sysclk);
    checkOutput("err_any_set", {31'b0, o_err_any}, 32'd1);
    applyStimulus(1'b1, A_ERR, 32'h4, 8'h04);
    applyStimulus(1'b0, A_ERR, 32'h0, 8'h00);
    applyStimulus(1'b1, A_ERR, 32'h4, 8'h00);
    applyStimulus(1'b0, A_ERR, 32'h0, 8'h00);
    repeat (2) @(negedge i_sysclk);
    checkOutput("err_any_clear", {31'b0, o_err_any}, 32'd0);

    // Decode misses with no side effects
    applyStimulus(1'b0, 26'h224_0008, 32'h0, 8'h00);
    applyStimulus(1'b0, 26'h223_1008, 32'h0, 8'h00);
    applyStimulus(1'b0, 26'h223_000C, 32'h0, 8'h00);
    applyStimulus(1'b1, 26'h224_0008, 32'h33, 8'h00);
    applyStimulus(1'b1, 26'h223_1000, 32'h1, 8'h00);
    applyStimulus(1'b0, A_CHAN, 32'h0, 8'h00);
    repeat (2) @(negedge i_sysclk);
    checkOutput("miss_no_pulse", {31'b0, o_dsp_reset}, 32'd0);

    // Response held for five cycles of back-pressure
    readyMode = 2;
    repeat (2) @(posedge i_sysclk);
    applyStimulus(1'b0, A_CHAN, 32'h0, 8'h00);
    repeat (5) begin
      @(negedge i_sysclk);
      checkOutput("hold_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
      checkOutput("hold_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    end
    readyMode = 1;
    repeat (4) @(posedge i_sysclk);

    // Asynchronous reset while a response is pending
    readyMode = 2;
    repeat (2) @(posedge i_sysclk);
    applyStimulus(1'b1, A_CHAN, 32'h77, 8'h00);
    @(posedge i_sysclk); #3;
    i_rst = 1'b1;
    #1;
    checkOutput("abort_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("abort_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);
    @(posedge i_sysclk); #1;
    i_rst = 1'b0;
    readyMode = 1;
    repeat (4) begin
      @(negedge i_sysclk);
      checkOutput("no_late_rsp", {31'b0, o_rsp_valid}, 32'd0);
    end
    checkOutput("abort_chan_cleared", {24'b0, o_dsp_channel}, 32'd0);

    // Randomised traffic with back-pressure and error events
    readyMode = 0;
    for (int i = 0; i < 200; i++) begin
      int gap;
      applyStimulus(1'($urandom_range(0, 1)), addrPick[$urandom_range(0, 6)], $urandom,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge i_sysclk); #1;
        i_err_set = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
      i_err_set = 8'h00;
    end

    readyMode = 1;
    repeat (40) @(posedge i_sysclk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
